ps2_key_collector: RTL and testbench

- Sits between the PS2 byte receiver and the user-input/FSM stage of the ATM datapath.
- Consumes raw set-2 scancode bytes and strips break (F0) and extended (E0) sequences.
- Converts digit make codes to BCD and accumulates a multi-digit entry (account number, PIN, amount) with backspace, escape and enter editing.
- Produces a single-key event per press for menu selection, and a completed-entry pulse with the packed BCD value.

---
 rtl/ps2_pkg.sv | 42 ++++
 rtl/ps2_scan_to_key.sv | 44 ++++
 rtl/ps2_key_collector.sv | 143 ++++++++++++++
 tb/tb_ps2_key_collector.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants for the PS2 key collector: set-2 scancodes, key codes
// and the prefix-state encoding.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;
  localparam logic [7:0] SC_ESC   = 8'h76;

  localparam logic [7:0] SC_D0 = 8'h45;
  localparam logic [7:0] SC_D1 = 8'h16;
  localparam logic [7:0] SC_D2 = 8'h1E;
  localparam logic [7:0] SC_D3 = 8'h26;
  localparam logic [7:0] SC_D4 = 8'h25;
  localparam logic [7:0] SC_D5 = 8'h2E;
  localparam logic [7:0] SC_D6 = 8'h36;
  localparam logic [7:0] SC_D7 = 8'h3D;
  localparam logic [7:0] SC_D8 = 8'h3E;
  localparam logic [7:0] SC_D9 = 8'h46;

  localparam logic [7:0] SC_KP0 = 8'h70;
  localparam logic [7:0] SC_KP1 = 8'h69;
  localparam logic [7:0] SC_KP2 = 8'h72;
  localparam logic [7:0] SC_KP3 = 8'h7A;
  localparam logic [7:0] SC_KP4 = 8'h6B;
  localparam logic [7:0] SC_KP5 = 8'h73;
  localparam logic [7:0] SC_KP6 = 8'h74;
  localparam logic [7:0] SC_KP7 = 8'h6C;
  localparam logic [7:0] SC_KP8 = 8'h75;
  localparam logic [7:0] SC_KP9 = 8'h7D;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ESC   = 4'hC;

  localparam logic [1:0] P_IDLE    = 2'd0;
  localparam logic [1:0] P_BRK     = 2'd1;
  localparam logic [1:0] P_EXT     = 2'd2;
  localparam logic [1:0] P_EXT_BRK = 2'd3;

endpackage

// File: rtl/ps2_scan_to_key.sv
// Combinational map from a set-2 make code to {hit, key_code}.
// Keypad digit codes are mapped only when PS2_KEYPAD_DIGITS_EN is defined.
module ps2_scan_to_key
  import ps2_pkg::*;
(
  input  logic [7:0] code,
  output logic       hit,
  output logic [3:0] key_code
);

  always_comb begin
    hit      = 1'b1;
    key_code = 4'h0;
    case (code)
      SC_D0:    key_code = 4'd0;
      SC_D1:    key_code = 4'd1;
      SC_D2:    key_code = 4'd2;
      SC_D3:    key_code = 4'd3;
      SC_D4:    key_code = 4'd4;
      SC_D5:    key_code = 4'd5;
      SC_D6:    key_code = 4'd6;
      SC_D7:    key_code = 4'd7;
      SC_D8:    key_code = 4'd8;
      SC_D9:    key_code = 4'd9;
      SC_ENTER: key_code = KEY_ENTER;
      SC_BKSP:  key_code = KEY_BKSP;
      SC_ESC:   key_code = KEY_ESC;
`ifdef PS2_KEYPAD_DIGITS_EN
      SC_KP0:   key_code = 4'd0;
      SC_KP1:   key_code = 4'd1;
      SC_KP2:   key_code = 4'd2;
      SC_KP3:   key_code = 4'd3;
      SC_KP4:   key_code = 4'd4;
      SC_KP5:   key_code = 4'd5;
      SC_KP6:   key_code = 4'd6;
      SC_KP7:   key_code = 4'd7;
      SC_KP8:   key_code = 4'd8;
      SC_KP9:   key_code = 4'd9;
`endif
      default:  hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_key_collector.sv
// Strips F0/E0 prefixes from set-2 scancodes and collects BCD digit entries
// with backspace/escape/enter editing. Option: PS2_KEYPAD_DIGITS_EN.
module ps2_key_collector
  import ps2_pkg::*;
#(
  parameter int MAX_DIGITS = 4,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid,
  input  logic                    clear,
  output logic                    key_valid,
  output logic [3:0]              key_code,
  output logic [4*MAX_DIGITS-1:0] digits,
  output logic [CNT_W-1:0]        count,
  output logic                    entry_done,
  output logic [4*MAX_DIGITS-1:0] entry_value,
  output logic                    overflow
);

  localparam int              DW      = 4 * MAX_DIGITS;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_DIGITS);

  logic [1:0]       pstate, pstate_nxt;
  logic             map_hit;
  logic [3:0]       map_key;
  logic             is_prefix;
  logic             ev_hit;
  logic [DW-1:0]    bcd_ext;
  logic [DW-1:0]    digits_nxt, entry_value_nxt;
  logic [CNT_W-1:0] count_nxt;
  logic [3:0]       key_code_nxt;
  logic             key_valid_nxt, entry_done_nxt, overflow_nxt;

  ps2_scan_to_key u_map (
    .code     (byte_in),
    .hit      (map_hit),
    .key_code (map_key)
  );

  assign is_prefix = (byte_in == SC_BREAK) || (byte_in == SC_EXT);

  // Prefix tracking; clear flushes it and drops a coincident byte
  always_comb begin
    pstate_nxt = pstate;
    ev_hit     = 1'b0;
    if (clear) begin
      pstate_nxt = P_IDLE;
    end else if (byte_valid) begin
      case (pstate)
        P_IDLE: begin
          if (byte_in == SC_BREAK)    pstate_nxt = P_BRK;
          else if (byte_in == SC_EXT) pstate_nxt = P_EXT;
          ev_hit = !is_prefix && map_hit;
        end
        P_EXT: begin
          pstate_nxt = (byte_in == SC_BREAK) ? P_EXT_BRK : P_IDLE;
          ev_hit     = (byte_in == SC_ENTER);
        end
        default: pstate_nxt = P_IDLE;
      endcase
    end
  end

  always_comb begin
    bcd_ext      = '0;
    bcd_ext[3:0] = map_key;
  end

  // Entry buffer editing for the single event a byte can produce
  always_comb begin
    digits_nxt      = digits;
    count_nxt       = count;
    entry_value_nxt = entry_value;
    key_code_nxt    = key_code;
    key_valid_nxt   = 1'b0;
    entry_done_nxt  = 1'b0;
    overflow_nxt    = 1'b0;
    if (clear) begin
      digits_nxt = '0;
      count_nxt  = '0;
    end else if (ev_hit) begin
      key_valid_nxt = 1'b1;
      key_code_nxt  = map_key;
      if (map_key <= 4'd9) begin
        if (count < MAX_CNT) begin
          digits_nxt = (digits << 4) | bcd_ext;
          count_nxt  = count + CNT_W'(1);
        end else begin
          overflow_nxt = 1'b1;
        end
      end else begin
        case (map_key)
          KEY_BKSP: begin
            if (count != '0) begin
              digits_nxt = digits >> 4;
              count_nxt  = count - CNT_W'(1);
            end
          end
          KEY_ESC: begin
            digits_nxt = '0;
            count_nxt  = '0;
          end
          KEY_ENTER: begin
            if (count != '0) begin
              entry_done_nxt  = 1'b1;
              entry_value_nxt = digits;
              digits_nxt      = '0;
              count_nxt       = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Registered outputs, one cycle after the accepted byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pstate      <= P_IDLE;
      digits      <= '0;
      count       <= '0;
      entry_value <= '0;
      key_code    <= '0;
      key_valid   <= 1'b0;
      entry_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      pstate      <= pstate_nxt;
      digits      <= digits_nxt;
      count       <= count_nxt;
      entry_value <= entry_value_nxt;
      key_code    <= key_code_nxt;
      key_valid   <= key_valid_nxt;
      entry_done  <= entry_done_nxt;
      overflow    <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_key_collector.sv
// Scoreboard bench for ps2_key_collector: expected key events are queued by
// the stimulus and popped by a monitor whenever the DUT pulses an output.
module tb_ps2_key_collector;

  localparam int MAX_DIGITS = 4;
  localparam int CNT_W      = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [7:0]              byte_in = 8'h00;
  logic                    byte_valid = 1'b0;
  logic                    clear = 1'b0;
  logic                    key_valid;
  logic [3:0]              key_code;
  logic [4*MAX_DIGITS-1:0] digits;
  logic [CNT_W-1:0]        count;
  logic                    entry_done;
  logic [4*MAX_DIGITS-1:0] entry_value;
  logic                    overflow;

  ps2_key_collector #(.MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .clear       (clear),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .digits      (digits),
    .count       (count),
    .entry_done  (entry_done),
    .entry_value (entry_value),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  kc;
    logic        done;
    logic [15:0] value;
    logic        ovf;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_key(input logic [3:0] kc);
    exp_q.push_back('{kc: kc, done: 1'b0, value: 16'h0, ovf: 1'b0});
  endtask

  task automatic exp_done(input logic [15:0] v);
    exp_q.push_back('{kc: 4'hA, done: 1'b1, value: v, ovf: 1'b0});
  endtask

  task automatic exp_ovf(input logic [3:0] kc);
    exp_q.push_back('{kc: kc, done: 1'b0, value: 16'h0, ovf: 1'b1});
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    byte_in = b; byte_valid = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: any pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (rst_n && (key_valid || entry_done || overflow)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: kv=%0b kc=%0h done=%0b ovf=%0b, none expected",
                 key_valid, key_code, entry_done, overflow);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("ev_key_valid", 32'(key_valid), 32'd1);
        chk("ev_key_code", 32'(key_code), 32'(e.kc));
        chk("ev_entry_done", 32'(entry_done), 32'(e.done));
        chk("ev_overflow", 32'(overflow), 32'(e.ovf));
        if (e.done) chk("ev_entry_value", 32'(entry_value), 32'(e.value));
      end
    end
  end

  initial begin
    idle(2);
    chk("rst_key_valid", 32'(key_valid), 32'd0);
    chk("rst_digits", 32'(digits), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_entry_done", 32'(entry_done), 32'd0);
    chk("rst_entry_value", 32'(entry_value), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;
    idle(1);

    // 1,2,3,4 with breaks, then enter
    exp_key(4'd1); exp_key(4'd2); exp_key(4'd3); exp_key(4'd4); exp_done(16'h1234);
    send(8'h16); send(8'hF0); send(8'h16);
    send(8'h1E); send(8'hF0); send(8'h1E);
    send(8'h26); send(8'hF0); send(8'h26);
    send(8'h25); send(8'hF0); send(8'h25);
    send(8'h5A); send(8'hF0); send(8'h5A);
    idle(1);
    chk("entry_value_1234", 32'(entry_value), 32'h1234);
    chk("count_after_enter", 32'(count), 32'd0);
    chk("digits_after_enter", 32'(digits), 32'd0);

    // Overflow on fifth digit
    exp_key(4'd1); exp_key(4'd2); exp_key(4'd3); exp_key(4'd4); exp_ovf(4'd5);
    send(8'h16); send(8'h1E); send(8'h26); send(8'h25); send(8'h2E);
    idle(1);
    chk("digits_full", 32'(digits), 32'h1234);
    chk("count_full", 32'(count), 32'd4);
    exp_key(4'hC);
    send(8'h76);

    // 7,8, backspace, 9, escape
    exp_key(4'd7); exp_key(4'd8); exp_key(4'hB); exp_key(4'd9);
    send(8'h3D); send(8'h3E); send(8'h66); send(8'h46);
    idle(1);
    chk("digits_bksp", 32'(digits), 32'h0079);
    chk("count_bksp", 32'(count), 32'd2);
    exp_key(4'hC);
    send(8'h76);
    idle(1);
    chk("digits_esc", 32'(digits), 32'd0);
    chk("count_esc", 32'(count), 32'd0);

    // Backspace on empty buffer and an unmapped code
    exp_key(4'hB);
    send(8'h66); send(8'h1C);
    idle(1);
    chk("count_empty_bksp", 32'(count), 32'd0);

    // Keypad enter, then extended break of enter
    exp_key(4'd4); exp_key(4'd5); exp_key(4'd6); exp_done(16'h0456);
    send(8'h25); send(8'h2E); send(8'h36);
    idle(1);
    chk("digits_456", 32'(digits), 32'h0456);
    send(8'hE0); send(8'h5A);
    send(8'hE0); send(8'hF0); send(8'h5A);
    exp_key(4'd1);
    send(8'h16);
    idle(1);
    chk("entry_value_0456", 32'(entry_value), 32'h0456);
    chk("count_after_ext", 32'(count), 32'd1);

    // Enter with count 0 is still a key event
    exp_key(4'hC); exp_key(4'hA);
    send(8'h76); send(8'h5A);

    // clear together with byte_valid drops the byte and flushes the buffer
    exp_key(4'd1);
    send(8'h16);
    @(posedge clk); #1;
    byte_in = 8'h16; byte_valid = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    byte_valid = 1'b0; clear = 1'b0;
    chk("count_clear", 32'(count), 32'd0);
    chk("digits_clear", 32'(digits), 32'd0);

    // clear also drops a pending break prefix
    send(8'hF0);
    @(posedge clk); #1; clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
    exp_key(4'd3);
    send(8'h26);
    idle(1);
    chk("count_clear_prefix", 32'(count), 32'd1);
    exp_key(4'hC);
    send(8'h76);

    // Reset after a lone F0; next byte is a make
    send(8'hF0);
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    exp_key(4'd2);
    send(8'h1E);
    idle(1);
    chk("count_after_reset", 32'(count), 32'd1);
    chk("digits_after_reset", 32'(digits), 32'h0002);

    // Keypad digit 1
`ifdef PS2_KEYPAD_DIGITS_EN
    exp_key(4'd1);
    send(8'h69);
    idle(1);
    chk("count_keypad", 32'(count), 32'd2);
    chk("digits_keypad", 32'(digits), 32'h0021);
`else
    send(8'h69);
    idle(1);
    chk("count_keypad", 32'(count), 32'd1);
    chk("digits_keypad", 32'(digits), 32'h0002);
`endif

    idle(3);
    chk("events_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
